loba_dot_acc: RTL and testbench

Streaming signed accumulator that sits directly downstream of the signed LOBA multipliers (LOBA0s–LOBA3s). It consumes one 2N-bit signed product per valid/ready handshake and sums a programmable number of products into one dot-product result. Each addition saturates. The result is emitted on a registered valid/ready output port with a sticky saturation flag.

---
 rtl/loba_dot_acc.sv | 138 +++++++++++++
 tb/tb_loba_dot_acc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loba_dot_acc.sv
// Streaming signed dot-product accumulator: sums cfg_len signed products per vector
// with per-addition saturation and presents each result on a registered valid/ready port.
module loba_dot_acc #(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_sat,
    output logic               busy
);

    localparam int unsigned SW = ACC_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_sat_q, out_sat_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic [ACC_W-1:0]   prod_ext;
    logic [SW-1:0]      sum_wide;
    logic               clamp;
    logic [ACC_W-1:0]   add_res;
    logic [LEN_W-1:0]   first_cnt;

    // Input stalls only while a finished result waits for the consumer.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Saturating add: one guard bit detects overflow, then clip to the signed range.
    always_comb begin
        prod_ext  = ACC_W'($signed(in_prod));
        sum_wide  = SW'($signed(acc_q)) + SW'($signed(prod_ext));
        clamp     = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        add_res   = sum_wide[ACC_W-1:0];
        if (clamp) begin
            add_res = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
        first_cnt = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && first_cnt != '0) state_d = ACC;
            ACC:  if (accept && cnt_q == LEN_W'(1)) state_d = IDLE;
        endcase
    end

    // Datapath and result update; a completion in the same cycle as an output
    // handshake reloads the result and keeps out_valid high.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    acc_d = prod_ext;
                    sat_d = 1'b0;
                    cnt_d = first_cnt;
                    if (first_cnt == '0) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = prod_ext;
                        out_sat_d   = 1'b0;
                    end
                end
                ACC: begin
                    acc_d = add_res;
                    sat_d = sat_q | clamp;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = add_res;
                        out_sat_d   = sat_q | clamp;
                    end
                end
            endcase
        end
        busy_d = (state_d == ACC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_loba_dot_acc.sv
// Bench for loba_dot_acc: a 40-bit and a 34-bit instance share stimulus and are
// compared each cycle against a vector-level saturating-sum reference.
module tb_loba_dot_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        out_ready;

    logic        rdy40, ov40, sat40, busy40;
    logic [39:0] sum40;
    logic        rdy34, ov34, sat34, busy34;
    logic [33:0] sum34;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: products collected for the open vector, and the held result.
    longint vec[$];
    int     target;
    bit     m_ov;
    longint m_sum40, m_sum34;
    bit     m_sat40, m_sat34;
    bit     e_rdy, e_busy;

    loba_dot_acc #(.N(16), .ACC_W(40), .LEN_W(8)) dut40 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(rdy40),
        .in_prod(in_prod), .out_valid(ov40), .out_ready(out_ready), .out_sum(sum40),
        .out_sat(sat40), .busy(busy40));

    loba_dot_acc #(.N(16), .ACC_W(34), .LEN_W(8)) dut34 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(rdy34),
        .in_prod(in_prod), .out_valid(ov34), .out_ready(out_ready), .out_sum(sum34),
        .out_sat(sat34), .busy(busy34));

    always #5 clk = ~clk;

    function automatic longint clip(input longint v, input int w, output bit c);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        c = 1'b0;
        if (v > mx) begin c = 1'b1; return mx; end
        if (v < mn) begin c = 1'b1; return mn; end
        return v;
    endfunction

    function automatic void fold(input int w, output longint s, output bit st);
        s  = vec[0];
        st = 1'b0;
        for (int i = 1; i < vec.size(); i++) begin
            bit c;
            s  = clip(s + vec[i], w, c);
            st = st | c;
        end
    endfunction

    task automatic model_reset();
        vec.delete();
        m_ov   = 1'b0;
        e_busy = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [31:0] p, input logic [7:0] len, input bit ordy);
        in_valid  = v;
        in_prod   = p;
        cfg_len   = len;
        out_ready = ordy;
        #1;
        e_rdy = !m_ov || ordy;
    endtask

    task automatic tick();
        bit done;
        done = 1'b0;
        if (in_valid && e_rdy) begin
            if (vec.size() == 0) target = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
            vec.push_back(longint'($signed(in_prod)));
            if (vec.size() == target) begin
                fold(40, m_sum40, m_sat40);
                fold(34, m_sum34, m_sat34);
                vec.delete();
                done = 1'b1;
            end
        end
        if (done) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        e_busy = (vec.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; cfg_len = '0; out_ready = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if ({ov40, sat40, busy40, rdy40, ov34, sat34, busy34, rdy34} !== 8'b0001_0001
            || sum40 !== 40'd0 || sum34 !== 34'd0) begin
            n_fail++;
            $display("FAIL reset: v=%b sat=%b busy=%b rdy=%b sum=%0d want 0,0,0,1,0",
                     ov40, sat40, busy40, rdy40, sum40);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] p[6] = '{32'd100, -32'sd30, 32'd7, 32'd1, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, p[i], 8'd4, 1'b1);
            n_vec++;
            if ({rdy40, rdy34} !== {2{e_rdy}}) begin
                n_fail++; $display("FAIL basic in_ready: got %b want %b", rdy40, e_rdy);
            end
            tick();
            n_vec++;
            if ({ov40, busy40} !== {m_ov, e_busy} || (m_ov && {sum40, sat40} !== {40'(m_sum40), m_sat40})) begin
                n_fail++;
                $display("FAIL basic out: got v=%b b=%b sum=%0d sat=%b want v=%b b=%b sum=%0d sat=%b",
                         ov40, busy40, $signed(sum40), sat40, m_ov, e_busy, m_sum40, m_sat40);
            end
            if (i == 3) begin
                n_vec++;
                if (ov40 !== 1'b1 || sum40 !== 40'd78 || sat40 !== 1'b0) begin
                    n_fail++; $display("FAIL basic result: got v=%b sum=%0d want v=1 sum=78", ov40, sum40);
                end
            end
        end
    endtask

    task automatic test_len01();
        logic [31:0] p[3] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0};
        logic [7:0]  l[3] = '{8'd0, 8'd1, 8'd1};
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, p[i], l[i], 1'b1);
            n_vec++;
            if ({rdy40, rdy34} !== {2{e_rdy}}) begin
                n_fail++; $display("FAIL len01 in_ready: got %b want %b", rdy40, e_rdy);
            end
            tick();
            n_vec++;
            if ({ov40, busy40, busy34} !== {m_ov, 2'b00}
                || (m_ov && {sum40, sat40, sum34} !== {40'(m_sum40), m_sat40, 34'(m_sum34)})) begin
                n_fail++;
                $display("FAIL len01 out: got v=%b b=%b sum=%0d want v=%b b=0 sum=%0d",
                         ov40, busy40, $signed(sum40), m_ov, m_sum40);
            end
        end
    endtask

    task automatic sat_vector(input string name, input logic [31:0] p, input logic [33:0] want34);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, p, 8'd10, 1'b1);
            n_vec++;
            if ({rdy40, rdy34} !== {2{e_rdy}}) begin
                n_fail++; $display("FAIL %s in_ready: got %b want %b", name, rdy34, e_rdy);
            end
            tick();
            n_vec++;
            if ({ov40, ov34, busy34} !== {m_ov, m_ov, e_busy}
                || (m_ov && {sum40, sat40, sum34, sat34} !== {40'(m_sum40), m_sat40, 34'(m_sum34), m_sat34})) begin
                n_fail++;
                $display("FAIL %s out: got v=%b s34=%h sat34=%b s40=%h want v=%b s34=%h sat34=%b s40=%h",
                         name, ov34, sum34, sat34, sum40, m_ov, 34'(m_sum34), m_sat34, 40'(m_sum40));
            end
        end
        n_vec++;
        if (ov34 !== 1'b1 || sum34 !== want34 || sat34 !== 1'b1) begin
            n_fail++; $display("FAIL %s result34: got v=%b sum=%h sat=%b want sum=%h sat=1",
                               name, ov34, sum34, sat34, want34);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] p[3] = '{32'd3, 32'd4, 32'd0};
        sat_vector("possat", 32'h4000_0000, 34'h1_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, p[i], 8'd2, 1'b1);
            tick();
            n_vec++;
            if ({ov34, busy34} !== {m_ov, e_busy} || (m_ov && {sum34, sat34} !== {34'(m_sum34), m_sat34})) begin
                n_fail++;
                $display("FAIL satclear out: got v=%b sum=%0d sat=%b want v=%b sum=%0d sat=%b",
                         ov34, sum34, sat34, m_ov, m_sum34, m_sat34);
            end
        end
        n_vec++;
        if (m_sum34 != 64'sd7 || sat34 !== 1'b0 || sum34 !== 34'd7) begin
            n_fail++; $display("FAIL satclear result: got sum=%0d sat=%b want 7,0", sum34, sat34);
        end
    endtask

    task automatic test_neg_saturation();
        sat_vector("negsat", 32'hC000_0000, 34'h2_0000_0000);
    endtask

    task automatic test_backpressure();
        logic [31:0] q[$] = '{32'd1, 32'd2, 32'd3, 32'd4};
        for (int k = 0; k < 14; k++) begin
            bit has;
            has = (q.size() != 0);
            drive(has, has ? q[0] : 32'd0, 8'd2, k >= 7);
            n_vec++;
            if ({rdy40, rdy34} !== {2{e_rdy}}) begin
                n_fail++; $display("FAIL bp in_ready k=%0d: got %b want %b", k, rdy40, e_rdy);
            end
            if (has && e_rdy) void'(q.pop_front());
            tick();
            n_vec++;
            if ({ov40, busy40} !== {m_ov, e_busy} || (m_ov && {sum40, sat40} !== {40'(m_sum40), m_sat40})) begin
                n_fail++;
                $display("FAIL bp out k=%0d: got v=%b b=%b sum=%0d want v=%b b=%b sum=%0d",
                         k, ov40, busy40, sum40, m_ov, e_busy, m_sum40);
            end
        end
        n_vec++;
        if (q.size() != 0 || m_sum40 != 64'sd7) begin
            n_fail++; $display("FAIL bp drain: left=%0d last=%0d want 0 left, last 7", q.size(), m_sum40);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p[2] = '{32'd10, 32'd20};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, p[i], 8'd4, 1'b1);
            tick();
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({ov40, busy40, rdy40} !== 3'b001 || sum40 !== 40'd0) begin
            n_fail++; $display("FAIL rstmid: got v=%b b=%b rdy=%b sum=%0d want 0,0,1,0", ov40, busy40, rdy40, sum40);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 32'd9, 8'd1, 1'b1);
            tick();
            n_vec++;
            if ({ov40, busy40} !== {m_ov, e_busy} || (m_ov && {sum40, sat40} !== {40'd9, 1'b0})) begin
                n_fail++;
                $display("FAIL rstmid out: got v=%b b=%b sum=%0d want v=%b b=%b sum=9",
                         ov40, busy40, sum40, m_ov, e_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            logic [31:0] p;
            case ($urandom % 4)
                0: p = ($urandom % 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
                1: p = 32'($urandom % 64) - 32'd32;
                default: p = $urandom;
            endcase
            drive(($urandom % 4) != 0, p, 8'($urandom % 6), ($urandom % 3) != 0);
            n_vec++;
            if ({rdy40, rdy34} !== {2{e_rdy}}) begin
                n_fail++; $display("FAIL rand in_ready k=%0d: got %b/%b want %b", k, rdy40, rdy34, e_rdy);
            end
            tick();
            n_vec++;
            if ({ov40, ov34, busy40, busy34} !== {m_ov, m_ov, e_busy, e_busy}
                || (m_ov && {sum40, sat40, sum34, sat34} !== {40'(m_sum40), m_sat40, 34'(m_sum34), m_sat34})) begin
                n_fail++;
                $display("FAIL rand out k=%0d: got v=%b b=%b s40=%h/%b s34=%h/%b want v=%b b=%b s40=%h/%b s34=%h/%b",
                         k, ov40, busy40, sum40, sat40, sum34, sat34, m_ov, e_busy,
                         40'(m_sum40), m_sat40, 34'(m_sum34), m_sat34);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len01();
        test_saturation();
        test_neg_saturation();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
